overload_detector: RTL and testbench

OVERLOAD_DETECTOR -- requirements
Module: overload_detector

---
 rtl/overload_detector.sv | 137 +++++++++++++
 tb/tb_overload_detector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/overload_detector.sv
// Windowed overload detector on the VGA output, feeding the AGC a registered decision.
// Optional macro OVLD_HYSTERESIS_EN: overload releases only after two consecutive clean windows.
module overload_detector #(
  parameter int WINDOW_LEN  = 16,
  parameter int THRESHOLD   = 7,
  parameter int HIT_COUNT   = 2,
  parameter int HOLDOFF_LEN = 8
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       sample_valid,
  input  logic [3:0] amplified_signal,
  input  logic [5:0] gain_code,
  output logic       overload,
  output logic [3:0] peak_out,
  output logic       window_done,
  output logic       dbg_state_o
);

  localparam int SW = $clog2(WINDOW_LEN);
  localparam int HW = SW + 1;
  localparam logic [SW-1:0] LAST_IDX  = SW'(WINDOW_LEN - 1);
  localparam logic [HW-1:0] HIT_MAX   = HW'(WINDOW_LEN);
  localparam logic [HW-1:0] HIT_REQ   = HW'(HIT_COUNT);
  localparam logic [3:0]    THR       = 4'(THRESHOLD);
  localparam logic [7:0]    HOLD_INIT = 8'(HOLDOFF_LEN);

  typedef enum logic {HOLDOFF = 1'b0, ACCUM = 1'b1} state_t;

  state_t        state_q;
  logic [7:0]    hold_q;
  logic [SW-1:0] cnt_q;
  logic [HW-1:0] hits_q, hits_d;
  logic [3:0]    win_peak_q, win_peak_d;
  logic [5:0]    gain_q;
  logic          gain_seen_q;
  logic          overload_q, window_done_q;
  logic [3:0]    peak_out_q;
  logic [3:0]    mag;
  logic          hit, hot, gain_chg;
`ifdef OVLD_HYSTERESIS_EN
  logic          clean_q;
`endif

  // sample_valid qualifies amplified_signal for one cycle; there is no backpressure,
  // and samples arriving outside ACCUM are dropped.
  always_comb begin
    mag        = amplified_signal[3] ? (4'd0 - amplified_signal) : amplified_signal;
    hit        = (mag >= THR);
    hits_d     = (hit && (hits_q != HIT_MAX)) ? (hits_q + HW'(1)) : hits_q;
    win_peak_d = (mag > win_peak_q) ? mag : win_peak_q;
    hot        = (hits_d >= HIT_REQ);
    // The first edge after reset only primes gain_q.
    gain_chg   = gain_seen_q && (gain_code != gain_q);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q       <= HOLDOFF;
      hold_q        <= HOLD_INIT;
      cnt_q         <= '0;
      hits_q        <= '0;
      win_peak_q    <= '0;
      gain_q        <= '0;
      gain_seen_q   <= 1'b0;
      overload_q    <= 1'b0;
      peak_out_q    <= '0;
      window_done_q <= 1'b0;
`ifdef OVLD_HYSTERESIS_EN
      clean_q       <= 1'b0;
`endif
    end else begin
      gain_q        <= gain_code;
      gain_seen_q   <= 1'b1;
      window_done_q <= 1'b0;
      if (gain_chg) begin
        // Gain change beats everything, including a window closing this cycle.
        state_q    <= HOLDOFF;
        hold_q     <= HOLD_INIT;
        cnt_q      <= '0;
        hits_q     <= '0;
        win_peak_q <= '0;
        overload_q <= 1'b0;
`ifdef OVLD_HYSTERESIS_EN
        clean_q    <= 1'b0;
`endif
      end else begin
        case (state_q)
          HOLDOFF: begin
            if (hold_q <= 8'd1) begin
              state_q    <= ACCUM;
              hold_q     <= '0;
              cnt_q      <= '0;
              hits_q     <= '0;
              win_peak_q <= '0;
            end else begin
              hold_q <= hold_q - 8'd1;
            end
          end
          ACCUM: begin
            if (sample_valid) begin
              if (cnt_q == LAST_IDX) begin
                window_done_q <= 1'b1;
                peak_out_q    <= win_peak_d;
                cnt_q         <= '0;
                hits_q        <= '0;
                win_peak_q    <= '0;
`ifdef OVLD_HYSTERESIS_EN
                if (hot) begin
                  overload_q <= 1'b1;
                  clean_q    <= 1'b0;
                end else begin
                  if (clean_q) overload_q <= 1'b0;
                  clean_q <= 1'b1;
                end
`else
                overload_q <= hot;
`endif
              end else begin
                cnt_q      <= cnt_q + SW'(1);
                hits_q     <= hits_d;
                win_peak_q <= win_peak_d;
              end
            end
          end
          default: state_q <= HOLDOFF;
        endcase
      end
    end
  end

  assign overload    = overload_q;
  assign peak_out    = peak_out_q;
  assign window_done = window_done_q;
  assign dbg_state_o = (state_q == ACCUM);

endmodule

// File: tb/tb_overload_detector.sv
// Bench for overload_detector: vector table, hand-built corner sequences, randomized run vs reference model.
module tb_overload_detector;

  localparam int WINDOW_LEN  = 16;
  localparam int THRESHOLD   = 7;
  localparam int HIT_COUNT   = 2;
  localparam int HOLDOFF_LEN = 8;

  logic       clk = 1'b0;
  logic       RESET;
  logic       sample_valid;
  logic [3:0] amplified_signal;
  logic [5:0] gain_code;
  logic       overload;
  logic [3:0] peak_out;
  logic       window_done;
  logic       dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  overload_detector #(
    .WINDOW_LEN(WINDOW_LEN), .THRESHOLD(THRESHOLD),
    .HIT_COUNT(HIT_COUNT), .HOLDOFF_LEN(HOLDOFF_LEN)
  ) dut (
    .clk(clk), .RESET(RESET), .sample_valid(sample_valid),
    .amplified_signal(amplified_signal), .gain_code(gain_code),
    .overload(overload), .peak_out(peak_out), .window_done(window_done),
    .dbg_state_o(dbg_state_o)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ignore;
  int         m_win[$];
  bit         m_gain_known;
  logic [5:0] m_last_gain;
  bit         m_ovl;
  int         m_peak;
  bit         m_done;
  int         m_clean;
  logic [4:0] exp_q[$];

  function automatic int mag_of(logic [3:0] s);
    int v;
    v = $signed(s);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_ignore = HOLDOFF_LEN;
    m_win.delete();
    m_gain_known = 0;
    m_last_gain = '0;
    m_ovl = 0;
    m_peak = 0;
    m_done = 0;
    m_clean = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit chg;
    bit hot;
    int hits;
    int pk;
    m_done = 0;
    chg = m_gain_known && (gain_code != m_last_gain);
    m_last_gain = gain_code;
    m_gain_known = 1;
    if (chg) begin
      m_win.delete();
      m_ignore = HOLDOFF_LEN;
      m_ovl = 0;
      m_clean = 0;
    end else if (m_ignore > 0) begin
      m_ignore--;
    end else if (sample_valid) begin
      m_win.push_back(mag_of(amplified_signal));
      if (m_win.size() == WINDOW_LEN) begin
        hits = 0;
        pk = 0;
        foreach (m_win[i]) begin
          if (m_win[i] >= THRESHOLD) hits++;
          if (m_win[i] > pk) pk = m_win[i];
        end
        hot = (hits >= HIT_COUNT);
`ifdef OVLD_HYSTERESIS_EN
        if (hot) begin
          m_ovl = 1;
          m_clean = 0;
        end else begin
          m_clean++;
          if (m_clean >= 2) m_ovl = 0;
        end
`else
        m_ovl = hot;
`endif
        m_peak = pk;
        m_done = 1;
        exp_q.push_back({m_ovl, 4'(pk)});
        m_win.delete();
      end
    end
  endtask

  always @(posedge clk) if (RESET === 1'b0) model_step();

  // Cycle monitor plus window scoreboard.
  always @(negedge clk) begin
    logic [4:0] got;
    if (RESET === 1'b0) begin
      check("mon_window_done", window_done, m_done);
      check("mon_overload", overload, m_ovl);
      check("mon_peak_out", peak_out, m_peak);
      if (window_done === 1'b1) begin
        if (exp_q.size() == 0) check("sb_pending", exp_q.size(), 1);
        else begin
          got = {overload, peak_out};
          check("sb_window", got, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(bit v, int s);
    sample_valid = v;
    amplified_signal = 4'(s);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_reset();
    #1;
    check("rst_overload", overload, 0);
    check("rst_peak_out", peak_out, 0);
    check("rst_window_done", window_done, 0);
    check("rst_state", dbg_state_o, 0);
    repeat (2) @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic count_to_done(bit toggle, int val, output int k);
    k = -1;
    for (int c = 1; c <= 60; c++) begin
      drive(toggle ? (c % 2 == 0) : 1'b1, val);
      if (window_done === 1'b1) begin
        k = c;
        break;
      end
    end
  endtask

  typedef struct {
    int fill;
    int spec;
    int nspec;
    bit exp_ovl;
    int exp_peak;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit mode;
    vecs[0] = '{3, 3, 0, 1'b0, 3};
    vecs[1] = '{3, -8, 2, 1'b1, 8};
    vecs[2] = '{3, 7, 1, 1'b0, 7};
    vecs[3] = '{0, -7, 2, 1'b1, 7};
    vecs[4] = '{6, 6, 0, 1'b0, 6};
    vecs[5] = '{-3, 7, 16, 1'b1, 7};
    vecs[6] = '{0, 0, 0, 1'b0, 0};
    vecs[7] = '{-2, -8, 1, 1'b0, 8};
    vecs[8] = '{2, -6, 5, 1'b0, 6};

    sample_valid = 1'b0;
    amplified_signal = '0;
    gain_code = 6'd63;
    do_reset();

    // Holdoff lasts exactly HOLDOFF_LEN cycles.
    repeat (HOLDOFF_LEN - 1) drive(0, 0);
    check("holdoff_still", dbg_state_o, 0);
    drive(0, 0);
    check("holdoff_done", dbg_state_o, 1);

    // Back-to-back windows from the vector table.
    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < WINDOW_LEN; i++)
        drive(1, (i < vecs[r].nspec) ? vecs[r].spec : vecs[r].fill);
      check($sformatf("vec%0d_done", r), window_done, 1);
`ifndef OVLD_HYSTERESIS_EN
      check($sformatf("vec%0d_overload", r), overload, vecs[r].exp_ovl);
`endif
      check($sformatf("vec%0d_peak", r), peak_out, vecs[r].exp_peak);
      drive(0, 0);
      check($sformatf("vec%0d_pulse", r), window_done, 0);
    end

    // Gain change mid-window while overloaded.
    for (int i = 0; i < WINDOW_LEN; i++) drive(1, (i < 2) ? -8 : 1);
    check("pre_gain_overload", overload, 1);
    repeat (5) drive(1, 3);
    gain_code = 6'd56;
    drive(1, 3);
    check("gain_overload_clr", overload, 0);
    check("gain_no_done", window_done, 0);
    check("gain_peak_kept", peak_out, 8);
    count_to_done(0, 3, k);
    check("gain_next_decision", k, HOLDOFF_LEN + WINDOW_LEN);
    check("gain_next_peak", peak_out, 3);

    // Gain change on the closing sample wins.
    for (int i = 0; i < WINDOW_LEN; i++) drive(1, -8);
    check("hot_again", overload, 1);
    for (int i = 0; i < WINDOW_LEN - 1; i++) drive(1, -8);
    gain_code = 6'd40;
    drive(1, -8);
    check("coincide_no_done", window_done, 0);
    check("coincide_overload", overload, 0);

    // Alternating sample_valid: 16 valid samples take 32 cycles.
    repeat (HOLDOFF_LEN) drive(0, 0);
    count_to_done(1, 3, k);
    check("toggle_cycles", k, 2 * WINDOW_LEN);

    // Reset in the middle of a window.
    repeat (7) drive(1, -8);
    do_reset();
    count_to_done(0, 5, k);
    check("rst_first_decision", k, HOLDOFF_LEN + WINDOW_LEN);
    check("rst_first_peak", peak_out, 5);
    check("rst_first_overload", overload, 0);

`ifdef OVLD_HYSTERESIS_EN
    for (int i = 0; i < WINDOW_LEN; i++) drive(1, (i < 2) ? 7 : 0);
    check("hyst_hot", overload, 1);
    for (int i = 0; i < WINDOW_LEN; i++) drive(1, 2);
    check("hyst_clean1", overload, 1);
    for (int i = 0; i < WINDOW_LEN; i++) drive(1, 2);
    check("hyst_clean2", overload, 0);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    mode = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) mode = $urandom_range(0, 1);
      if ($urandom_range(0, 149) == 0) gain_code = 6'($urandom_range(0, 63));
      drive($urandom_range(0, 3) != 0, mode ? $urandom_range(0, 15) : $urandom_range(0, 5));
    end
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
